// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file writeback block:
// datapath sizes, writeback source encoding and the pending-counter update rule.
package regfile_pkg;

    localparam int XLEN      = 32;
    localparam int REG_COUNT = 32;
    localparam int PEND_MAX  = 3;
    localparam int ADDR_W    = $clog2(REG_COUNT);
    localparam int CNT_W     = 2;

    localparam logic [CNT_W-1:0] PEND_MAX_C = CNT_W'(PEND_MAX);

    typedef enum logic {
        WB_ALU = 1'b0,
        WB_MEM = 1'b1
    } wb_src_t;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_req_t;

    // Saturating up/down step; simultaneous inc and dec cancel out.
    function automatic logic [CNT_W-1:0] pend_next(
        input logic [CNT_W-1:0] cnt,
        input logic             inc,
        input logic             dec
    );
        logic [CNT_W-1:0] nxt;
        nxt = cnt;
        case ({inc, dec})
            2'b10: begin
                if (cnt == PEND_MAX_C) begin
                    nxt = cnt;
                end else begin
                    nxt = cnt + 2'd1;
                end
            end
            2'b01: begin
                if (cnt == 2'd0) begin
                    nxt = cnt;
                end else begin
                    nxt = cnt - 2'd1;
                end
            end
            default: nxt = cnt;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/reg_pending_counter.sv
// Per-register count of in-flight writes: increments on issue, decrements on
// retire, saturating at both ends.
module reg_pending_counter
    import regfile_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic inc_i,
    input  logic dec_i,
    output logic nonzero_o,
    output logic full_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count from the shared saturating rule.
    always_comb begin
        cnt_d = pend_next(cnt_q, inc_i, dec_i);
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign nonzero_o = (cnt_q != {CNT_W{1'b0}});
    assign full_o    = (cnt_q == PEND_MAX_C);

endmodule

// File: rtl/regfile_writeback.sv
// Writeback arbiter and scoreboard: merges ALU and load results into the single
// register-file write port and tracks outstanding writes to flag RAW hazards.
module regfile_writeback
    import regfile_pkg::*;
(
    input  logic              clk,
    input  logic              rst,

    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_rd,
    output logic              issue_ready,

    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]   alu_data,
    output logic              alu_ready,

    input  logic              mem_valid,
    input  logic [ADDR_W-1:0] mem_rd,
    input  logic [XLEN-1:0]   mem_data,
    output logic              mem_ready,

    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic              hazard,

    output logic              wr_ena,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [XLEN-1:0]   wr_data
);

    logic                 wr_ena_q,     wr_ena_d;
    logic [ADDR_W-1:0]    wr_addr_q,    wr_addr_d;
    logic [XLEN-1:0]      wr_data_q,    wr_data_d;
    wb_src_t              last_grant_q, last_grant_d;

    logic                 alu_grant;
    logic                 mem_grant;
    logic                 xfer_valid;
    wb_req_t              xfer_req;
    logic                 issue_fire;

    logic [REG_COUNT-1:1] pend_inc;
    logic [REG_COUNT-1:1] pend_dec;
    logic [REG_COUNT-1:0] pend_nonzero;
    logic [REG_COUNT-1:0] pend_full;

    // x0 never has writes in flight, so it can never be full or pending.
    assign pend_nonzero[0] = 1'b0;
    assign pend_full[0]    = 1'b0;

    assign issue_ready = (issue_rd == {ADDR_W{1'b0}}) | ~pend_full[issue_rd];
    assign issue_fire  = issue_valid & issue_ready;

    genvar r;
    generate
        for (r = 1; r < REG_COUNT; r++) begin : g_pend
            assign pend_inc[r] = issue_fire & (issue_rd == ADDR_W'(r));
            assign pend_dec[r] = wr_ena_q & (wr_addr_q == ADDR_W'(r));

            reg_pending_counter u_cnt (
                .clk       (clk),
                .rst       (rst),
                .inc_i     (pend_inc[r]),
                .dec_i     (pend_dec[r]),
                .nonzero_o (pend_nonzero[r]),
                .full_o    (pend_full[r])
            );
        end
    endgenerate

    assign hazard = pend_nonzero[rs1_addr] | pend_nonzero[rs2_addr];

    // Round-robin grant: on a tie the source that did not win last time goes.
    always_comb begin
        alu_grant = 1'b0;
        mem_grant = 1'b0;
        if (alu_valid && (!mem_valid || (last_grant_q == WB_MEM))) begin
            alu_grant = 1'b1;
        end else if (mem_valid) begin
            mem_grant = 1'b1;
        end else begin
            alu_grant = 1'b0;
            mem_grant = 1'b0;
        end
    end

    assign alu_ready  = alu_grant;
    assign mem_ready  = mem_grant;
    assign xfer_valid = alu_grant | mem_grant;

    // Select the winning request payload.
    always_comb begin
        xfer_req = '{rd: {ADDR_W{1'b0}}, data: {XLEN{1'b0}}};
        case ({alu_grant, mem_grant})
            2'b10:   xfer_req = '{rd: alu_rd, data: alu_data};
            2'b01:   xfer_req = '{rd: mem_rd, data: mem_data};
            default: xfer_req = '{rd: {ADDR_W{1'b0}}, data: {XLEN{1'b0}}};
        endcase
    end

    // Next write-port state; x0 writes complete the handshake but are dropped.
    always_comb begin
        wr_ena_d     = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        last_grant_d = last_grant_q;
        if (xfer_valid) begin
            last_grant_d = alu_grant ? WB_ALU : WB_MEM;
        end else begin
            last_grant_d = last_grant_q;
        end
        if (xfer_valid && (xfer_req.rd != {ADDR_W{1'b0}})) begin
            wr_ena_d  = 1'b1;
            wr_addr_d = xfer_req.rd;
            wr_data_d = xfer_req.data;
        end else begin
            wr_ena_d  = 1'b0;
        end
    end

    // Write-port and arbiter registers; reset also kills an in-flight write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ena_q     <= 1'b0;
            wr_addr_q    <= {ADDR_W{1'b0}};
            wr_data_q    <= {XLEN{1'b0}};
            last_grant_q <= WB_MEM;
        end else begin
            wr_ena_q     <= wr_ena_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign wr_ena  = wr_ena_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback: a vector table for single-cycle
// behaviour plus short sequences for saturation and reset corner cases.
module tb_regfile_writeback;

    logic        clk;
    logic        rst;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_ready;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        mem_valid;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        hazard;
    logic        wr_ena;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;

    int n_checks = 0;
    int n_errors = 0;

    regfile_writeback dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_ready (issue_ready),
        .alu_valid   (alu_valid),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .alu_ready   (alu_ready),
        .mem_valid   (mem_valid),
        .mem_rd      (mem_rd),
        .mem_data    (mem_data),
        .mem_ready   (mem_ready),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .hazard      (hazard),
        .wr_ena      (wr_ena),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;  logic [4:0] ird;
        logic        av;  logic [4:0] ard; logic [31:0] ad;
        logic        mv;  logic [4:0] mrd; logic [31:0] md;
        logic [4:0]  rs1; logic [4:0] rs2;
        logic        e_ir; logic e_ar; logic e_mr; logic e_hz;
        logic        e_we; logic [4:0] e_wa; logic [31:0] e_wd;
    } vec_t;

    vec_t vecs[21];

    function automatic vec_t mk(
        input logic iv, input logic [4:0] ird,
        input logic av, input logic [4:0] ard, input logic [31:0] ad,
        input logic mv, input logic [4:0] mrd, input logic [31:0] md,
        input logic [4:0] rs1, input logic [4:0] rs2,
        input logic e_ir, input logic e_ar, input logic e_mr, input logic e_hz,
        input logic e_we, input logic [4:0] e_wa, input logic [31:0] e_wd
    );
        vec_t v;
        v.iv = iv; v.ird = ird; v.av = av; v.ard = ard; v.ad = ad;
        v.mv = mv; v.mrd = mrd; v.md = md; v.rs1 = rs1; v.rs2 = rs2;
        v.e_ir = e_ir; v.e_ar = e_ar; v.e_mr = e_mr; v.e_hz = e_hz;
        v.e_we = e_we; v.e_wa = e_wa; v.e_wd = e_wd;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", nm, $time, act, exp);
        end
    endtask

    task automatic idle_inputs();
        issue_valid = 1'b0; issue_rd = 5'd0;
        alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'h0;
        mem_valid = 1'b0; mem_rd = 5'd0; mem_data = 32'h0;
        rs1_addr = 5'd0; rs2_addr = 5'd0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // iv ird  av ard ad            mv mrd md            rs1 rs2  ir ar mr hz  we wa wd
        vecs[0]  = mk(0,0,  0,0,32'h0,         0,0,32'h0,         0,0,  1,0,0,0, 0,0,32'h0);
        vecs[1]  = mk(0,0,  1,1,32'h11111111,  1,2,32'h22222222,  1,2,  1,1,0,0, 1,1,32'h11111111);
        vecs[2]  = mk(0,0,  1,1,32'h11111111,  1,2,32'h22222222,  1,2,  1,0,1,0, 1,2,32'h22222222);
        vecs[3]  = mk(0,0,  1,1,32'h11111111,  1,2,32'h22222222,  1,2,  1,1,0,0, 1,1,32'h11111111);
        vecs[4]  = mk(0,0,  1,1,32'h11111111,  1,2,32'h22222222,  1,2,  1,0,1,0, 1,2,32'h22222222);
        vecs[5]  = mk(0,0,  0,0,32'h0,         0,0,32'h0,         1,2,  1,0,0,0, 0,2,32'h22222222);
        vecs[6]  = mk(1,5,  0,0,32'h0,         0,0,32'h0,         5,0,  1,0,0,0, 0,2,32'h22222222);
        vecs[7]  = mk(0,0,  1,5,32'hDEADBEEF,  0,0,32'h0,         5,0,  1,1,0,1, 1,5,32'hDEADBEEF);
        vecs[8]  = mk(0,0,  0,0,32'h0,         0,0,32'h0,         5,0,  1,0,0,1, 0,5,32'hDEADBEEF);
        vecs[9]  = mk(0,0,  0,0,32'h0,         0,0,32'h0,         5,0,  1,0,0,0, 0,5,32'hDEADBEEF);
        vecs[10] = mk(0,0,  0,0,32'h0,         1,0,32'h00001234,  0,0,  1,0,1,0, 0,5,32'hDEADBEEF);
        vecs[11] = mk(0,0,  0,0,32'h0,         0,0,32'h0,         0,0,  1,0,0,0, 0,5,32'hDEADBEEF);
        vecs[12] = mk(1,3,  0,0,32'h0,         0,0,32'h0,         3,0,  1,0,0,0, 0,5,32'hDEADBEEF);
        vecs[13] = mk(0,0,  1,3,32'h33333333,  0,0,32'h0,         3,0,  1,1,0,1, 1,3,32'h33333333);
        vecs[14] = mk(1,3,  0,0,32'h0,         0,0,32'h0,         3,0,  1,0,0,1, 0,3,32'h33333333);
        vecs[15] = mk(0,0,  0,0,32'h0,         0,0,32'h0,         3,0,  1,0,0,1, 0,3,32'h33333333);
        vecs[16] = mk(0,0,  1,3,32'h44444444,  0,0,32'h0,         3,0,  1,1,0,1, 1,3,32'h44444444);
        vecs[17] = mk(0,0,  0,0,32'h0,         0,0,32'h0,         3,0,  1,0,0,1, 0,3,32'h44444444);
        vecs[18] = mk(0,0,  0,0,32'h0,         0,0,32'h0,         3,0,  1,0,0,0, 0,3,32'h44444444);
        vecs[19] = mk(0,0,  1,6,32'h66666666,  1,8,32'h88888888,  6,8,  1,0,1,0, 1,8,32'h88888888);
        vecs[20] = mk(0,0,  0,0,32'h0,         0,0,32'h0,         6,8,  1,0,0,0, 0,8,32'h88888888);

        rst = 1'b1;
        idle_inputs();
        #12;
        check("rst_wr_ena",  {31'b0, wr_ena}, 32'd0);
        check("rst_wr_addr", {27'b0, wr_addr}, 32'd0);
        check("rst_wr_data", wr_data, 32'd0);
        check("rst_hazard",  {31'b0, hazard}, 32'd0);
        check("rst_issue_ready", {31'b0, issue_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        next_cycle();

        for (int i = 0; i < 21; i++) begin
            issue_valid = vecs[i].iv; issue_rd = vecs[i].ird;
            alu_valid = vecs[i].av; alu_rd = vecs[i].ard; alu_data = vecs[i].ad;
            mem_valid = vecs[i].mv; mem_rd = vecs[i].mrd; mem_data = vecs[i].md;
            rs1_addr = vecs[i].rs1; rs2_addr = vecs[i].rs2;
            #1;
            check($sformatf("v%0d_issue_ready", i), {31'b0, issue_ready}, {31'b0, vecs[i].e_ir});
            check($sformatf("v%0d_alu_ready", i),   {31'b0, alu_ready},   {31'b0, vecs[i].e_ar});
            check($sformatf("v%0d_mem_ready", i),   {31'b0, mem_ready},   {31'b0, vecs[i].e_mr});
            check($sformatf("v%0d_hazard", i),      {31'b0, hazard},      {31'b0, vecs[i].e_hz});
            next_cycle();
            check($sformatf("v%0d_wr_ena", i),  {31'b0, wr_ena},  {31'b0, vecs[i].e_we});
            check($sformatf("v%0d_wr_addr", i), {27'b0, wr_addr}, {27'b0, vecs[i].e_wa});
            check($sformatf("v%0d_wr_data", i), wr_data, vecs[i].e_wd);
        end

        // Fill x7 to saturation, then one retire frees a slot.
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            issue_valid = 1'b1; issue_rd = 5'd7;
            #1;
            check($sformatf("sat_issue%0d_ready", k), {31'b0, issue_ready}, 32'd1);
            next_cycle();
        end
        issue_valid = 1'b1; issue_rd = 5'd7; rs1_addr = 5'd7;
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77777777;
        #1;
        check("sat_full_ready", {31'b0, issue_ready}, 32'd0);
        check("sat_hazard", {31'b0, hazard}, 32'd1);
        check("sat_alu_ready", {31'b0, alu_ready}, 32'd1);
        next_cycle();
        check("sat_wr_ena", {31'b0, wr_ena}, 32'd1);
        check("sat_wr_addr", {27'b0, wr_addr}, 32'd7);
        alu_valid = 1'b0;
        #1;
        check("sat_retire_cycle_ready", {31'b0, issue_ready}, 32'd0);
        next_cycle();
        issue_valid = 1'b0;
        #1;
        check("sat_after_retire_ready", {31'b0, issue_ready}, 32'd1);
        check("sat_after_retire_hazard", {31'b0, hazard}, 32'd1);
        next_cycle();

        // Reset with a write in flight and pending hazards.
        idle_inputs();
        issue_valid = 1'b1; issue_rd = 5'd10;
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99999999;
        next_cycle();
        check("rstmid_wr_ena_before", {31'b0, wr_ena}, 32'd1);
        idle_inputs();
        rs1_addr = 5'd10; rs2_addr = 5'd7; issue_rd = 5'd7;
        #1;
        check("rstmid_hazard_before", {31'b0, hazard}, 32'd1);
        rst = 1'b1;
        #1;
        check("rstmid_wr_ena", {31'b0, wr_ena}, 32'd0);
        check("rstmid_wr_addr", {27'b0, wr_addr}, 32'd0);
        check("rstmid_wr_data", wr_data, 32'd0);
        check("rstmid_hazard", {31'b0, hazard}, 32'd0);
        check("rstmid_issue_ready", {31'b0, issue_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        next_cycle();
        check("rstmid_no_write", {31'b0, wr_ena}, 32'd0);
        for (int a = 0; a < 32; a++) begin
            rs1_addr = 5'(a); rs2_addr = 5'(a); issue_rd = 5'(a);
            #1;
            check($sformatf("post_rst_hazard_x%0d", a), {31'b0, hazard}, 32'd0);
            check($sformatf("post_rst_ready_x%0d", a), {31'b0, issue_ready}, 32'd1);
        end

        // After reset the first tie goes to the ALU again.
        idle_inputs();
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'hA1A1A1A1;
        mem_valid = 1'b1; mem_rd = 5'd2; mem_data = 32'hB2B2B2B2;
        #1;
        check("post_rst_tie_alu_ready", {31'b0, alu_ready}, 32'd1);
        check("post_rst_tie_mem_ready", {31'b0, mem_ready}, 32'd0);
        next_cycle();
        check("post_rst_tie_wr_addr", {27'b0, wr_addr}, 32'd1);
        check("post_rst_tie_wr_data", wr_data, 32'hA1A1A1A1);
        idle_inputs();
        next_cycle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile_writeback.md
REGFILE_WRITEBACK -- requirements
Module: regfile_writeback

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state updates on posedge.
REQ-002 SHALL have ports: rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: issue_valid  in  1  new instruction will write issue_rd; issue_rd  in  5; issue_ready  out  1.
REQ-004 SHALL have ports: alu_valid  in  1; alu_rd  in  5; alu_data  in  32; alu_ready  out  1  ALU result channel.
REQ-005 SHALL have ports: mem_valid  in  1; mem_rd  in  5; mem_data  in  32; mem_ready  out  1  load-data channel.
REQ-006 SHALL have ports: rs1_addr, rs2_addr  in  5 each  source registers of the decoding instruction; hazard  out  1.
REQ-007 SHALL have ports: wr_ena  out  1; wr_addr  out  5; wr_data  out  32  driving the register file write port.

Function
REQ-008 SHALL keep a 2-bit pending counter per register x01..x31; x00 has none and is never pending.
REQ-009 SHALL treat issue handshake as issue_valid & issue_ready; accepted issue with issue_rd!=0 increments that counter.
REQ-010 SHALL drive issue_ready low only when issue_rd!=0 and its counter equals 3; issue_rd==0 always ready, no state change.
REQ-011 SHALL accept at most one write source per cycle; a channel transfers on valid & ready.
REQ-012 SHALL arbitrate round-robin: sole valid source wins; when both valid, grant the source not granted last; last_grant updates only on a transfer.
REQ-013 SHALL generate ready combinationally: X_ready = X_valid & granted(X); ready SHALL never assert for an invalid channel.
REQ-014 SHALL register the granted write: transfer at edge N -> wr_ena=1, wr_addr=rd, wr_data=data during cycle N..N+1 (one-cycle latency).
REQ-015 SHALL drop writes to rd==0: transfer still completes, but wr_ena stays 0 and no counter changes.
REQ-016 SHALL drive wr_ena=0 in any cycle with no transfer on the previous edge; wr_addr/wr_data hold last value.
REQ-017 SHALL decrement the counter of wr_addr at the edge ending a wr_ena=1 cycle (data is then in the file).
REQ-018 SHALL leave a counter unchanged when increment and decrement hit the same register on one edge.
REQ-019 SHALL saturate at 0: a retire to a register with counter 0 still writes, counter stays 0.
REQ-020 SHALL compute hazard combinationally: (rs1_addr!=0 & cnt[rs1_addr]!=0) | (rs2_addr!=0 & cnt[rs2_addr]!=0).
REQ-021 SHALL not bypass/forward data; consumers stall on hazard.

Reset
REQ-022 SHALL on rst asynchronously clear all counters, wr_ena=0, wr_addr=0, wr_data=0, last_grant=MEM (ALU wins first tie).
REQ-023 SHALL discard any registered write in flight when rst asserts mid-operation; no write reaches the register file.
REQ-024 SHALL after rst deassertion report hazard=0 and issue_ready=1 for all addresses.

Structure
REQ-025 SHALL place XLEN=32, REG_COUNT=32, PEND_MAX=3 and enum wb_src_t {WB_ALU, WB_MEM} in shared package regfile_pkg.
REQ-026 SHALL implement each counter as sub-module reg_pending_counter (2-bit saturating up/down, inc/dec inputs, nonzero/full outputs), instantiated 31 times via generate.
REQ-027 SHALL contain no memory array inferred as RAM; counters are discrete flops.

Verification
REQ-028 SHALL cover: issue rd=5, then alu_valid rd=5 data=0xDEADBEEF -> alu_ready=1, next cycle wr_ena=1 wr_addr=5 wr_data=0xDEADBEEF; hazard for rs1=5 high until edge ending that cycle.
REQ-029 SHALL cover: alu and mem valid together for 4 cycles after reset -> grants ALU, MEM, ALU, MEM; wr_addr sequence matches.
REQ-030 SHALL cover: three issues rd=7 -> fourth issue_valid rd=7 sees issue_ready=0; one retire rd=7 -> issue_ready=1 next cycle.
REQ-031 SHALL cover: mem_valid rd=0 data=0x1234 -> mem_ready=1, wr_ena stays 0, hazard for rs2=0 stays 0.
REQ-032 SHALL cover: issue rd=3 on the same edge that retires rd=3 (counter 1) -> counter remains 1, hazard for rs1=3 stays 1.
REQ-033 SHALL cover: rst asserted while wr_ena=1 -> wr_ena drops to 0 immediately, all hazards clear, issue_ready=1.
